fft_stage_controller: RTL and testbench
=======================================

Name: fft_stage_controller

Overview:
Sequences the radix-2 butterfly datapath through a complete in-place N-point DIT FFT. Generates per-butterfly read addresses and twiddle indices for the sample RAM, and the matching write-back addresses and strobes, delayed by the RAM plus butterfly latency. Enforces a stage barrier so that no stage reads data before the previous stage has written it. Sits between the top-level FFT control (start/done) and the sample RAM / butterfly unit pair.

Parameters:
N, 32, FFT points (power of 2; twiddle index must fit 4 bits, so N ≤ 32)
LOG2N, 5, log2(N) = number of stages
ADDR_W, 5, sample RAM address width (= LOG2N)
RD_LATENCY, 1, cycles from rd_en/rd_addr to RAM data valid at butterfly input
BF_LATENCY, 3, cycles from butterfly input to butterfly output valid
WB_DELAY, RD_LATENCY+BF_LATENCY, issue-to-write-back delay (derived)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin FFT; sampled only in IDLE
rd_en  out  1  read strobe for both RAM ports
rd_addr_a  out  ADDR_W  upper-leg read address
rd_addr_b  out  ADDR_W  lower-leg read address
twiddle_num  out  4  twiddle index to butterfly, aligned with rd_addr
wr_en  out  1  write-back strobe for both RAM ports
wr_addr_a  out  ADDR_W  write address for butterfly output a
wr_addr_b  out  ADDR_W  write address for butterfly output b
stage  out  3  current stage index 0..LOG2N-1
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse when the last write-back has completed

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. k=0, stage=0, drain counter=0. Write-back pipeline valid bits all 0.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: if start=1, go to ISSUE with stage=0, k=0. busy=1 from the next cycle.
- ISSUE: rd_en=1 every cycle. k increments 0..N/2-1.
  - At k=N/2-1, go to DRAIN with drain counter cleared.
- DRAIN: rd_en=0 for exactly WB_DELAY cycles.
  - If stage<LOG2N-1: stage++, k=0, go to ISSUE.
  - Else go to FINISH.
- FINISH: done=1 and busy=0 for one cycle, then IDLE.
- Address math for stage s and butterfly k (registered outputs):
  - span = 1<<s
  - pos = k & (span-1)
  - grp = k >> s
  - rd_addr_a = (grp << (s+1)) | pos
  - rd_addr_b = rd_addr_a + span
  - twiddle_num = pos << (LOG2N-1-s)
- Write-back: a WB_DELAY-deep shift register carries {valid, addr_a, addr_b}. wr_en/wr_addr_* equal rd_en/rd_addr_* delayed exactly WB_DELAY cycles.
- Timing with start accepted at edge t:
  - Stage 0 reads occur in cycles t+1..t+N/2.
  - Writes occur in cycles t+1+WB_DELAY..t+N/2+WB_DELAY.
  - The next stage's first read is at cycle t+N/2+WB_DELAY+1, strictly after the last write (no RAW hazard).
  - Total: done at t+1+LOG2N*(N/2+WB_DELAY). Defaults: t+101.
- Input data is in bit-reversed order in RAM (loader's responsibility); output is natural order.
- start while busy: ignored, no restart, no error.
- start held high through FINISH: a new FFT is accepted only after returning to IDLE (earliest one cycle after done).
- rst mid-operation: next cycle, FSM=IDLE and all outputs 0, including wr_en. In-flight write-backs are discarded.

Decomposition:
- Shared package: N, LOG2N, ADDR_W, RD_LATENCY, BF_LATENCY, WB_DELAY, data width constant, FSM state encoding.
- One sub-module: fft_wb_delay, a parameterised shift register of {valid, addr_a, addr_b} with synchronous reset clearing the valid bits.

Test Plan:
- Reset then start pulse at t → stage 0 k=0: rd_addr_a=0, b=1, tw=0; k=1: a=2, b=3, tw=0. wr_en first high at t+5 with wr_addr_a=0, wr_addr_b=1.
- Stage 2, k=5 → rd_addr_a=9, rd_addr_b=13, twiddle_num=4. Stage 4, k=15 → a=15, b=31, tw=15. Full address/twiddle sequence checked against a reference model for all 80 butterflies.
- Barrier check: for every stage, the first rd_en cycle is later than the previous stage's last wr_en cycle. Exactly 16 wr_en cycles per stage, 80 total.
- start at t → done single pulse at t+101. busy high t+1..t+100. start pulses at t+10 and t+50 are ignored (same done time).
- rst asserted at t+30 → next cycle rd_en=wr_en=busy=0, stage=0. No wr_en afterwards. A new start then produces a clean run with done 100 cycles after first rd_en.
- start held high continuously → back-to-back FFTs, second run's first rd_en one cycle after IDLE re-entry. Sequence is identical to the first run.

Source files
------------

// File: rtl/fft_stage_controller_pkg.sv
// Shared constants, FSM encoding and butterfly address helpers
// for the in-place radix-2 DIT FFT stage controller.
package fft_stage_controller_pkg;

    localparam int N          = 32;
    localparam int LOG2N      = 5;
    localparam int ADDR_W     = LOG2N;
    localparam int RD_LATENCY = 1;
    localparam int BF_LATENCY = 3;
    localparam int WB_DELAY   = RD_LATENCY + BF_LATENCY;
    localparam int DATA_W     = 16;
    localparam int K_W        = LOG2N - 1;
    localparam int TW_W       = 4;
    localparam int STG_W      = 3;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } fsm_t;

    // Upper leg: insert a zero bit at position s of k.
    function automatic logic [ADDR_W-1:0] bf_addr_a(
        input logic [K_W-1:0]   k,
        input logic [STG_W-1:0] s
    );
        logic [ADDR_W-1:0] kk;
        logic [ADDR_W-1:0] mask;
        kk   = {1'b0, k};
        mask = (ADDR_W'(1) << s) - ADDR_W'(1);
        return ((kk & ~mask) << 1) | (kk & mask);
    endfunction

    function automatic logic [ADDR_W-1:0] bf_span(
        input logic [STG_W-1:0] s
    );
        return ADDR_W'(1) << s;
    endfunction

    function automatic logic [TW_W-1:0] bf_twiddle(
        input logic [K_W-1:0]   k,
        input logic [STG_W-1:0] s
    );
        logic [ADDR_W-1:0] kk;
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] tw;
        kk   = {1'b0, k};
        mask = (ADDR_W'(1) << s) - ADDR_W'(1);
        tw   = (kk & mask) << (STG_W'(LOG2N - 1) - s);
        return tw[TW_W-1:0];
    endfunction

endpackage

// File: rtl/fft_stage_controller_wb_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b}
// from read issue to butterfly write-back.
module fft_wb_delay #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr_a,
    input  logic [AW-1:0] in_addr_b,
    output logic          out_valid,
    output logic [AW-1:0] out_addr_a,
    output logic [AW-1:0] out_addr_b
);

    logic [DEPTH-1:0]         v_q;
    logic [DEPTH-1:0][AW-1:0] a_q;
    logic [DEPTH-1:0][AW-1:0] b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            v_q <= {v_q[DEPTH-2:0], in_valid};
            a_q <= {a_q[DEPTH-2:0], in_addr_a};
            b_q <= {b_q[DEPTH-2:0], in_addr_b};
        end
    end

    assign out_valid  = v_q[DEPTH-1];
    assign out_addr_a = a_q[DEPTH-1];
    assign out_addr_b = b_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_controller.sv
// Sequences butterflies through all stages of an in-place DIT FFT,
// with a drain barrier so each stage reads only written-back data.
module fft_stage_controller
    import fft_stage_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [TW_W-1:0]   twiddle_num,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b,
    output logic [STG_W-1:0]  stage,
    output logic              busy,
    output logic              done
);

    fsm_t             state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            stg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stg_q   <= stg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stg_d   = stg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    k_d     = '0;
                    stg_d   = '0;
                end
            end
            ISSUE: begin
                if (k_q == K_W'(N / 2 - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DRAIN: begin
                // Hold reads off until the last write of this stage lands.
                if (cnt_q == CNT_W'(WB_DELAY - 1)) begin
                    if (stg_q == STG_W'(LOG2N - 1)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                        stg_d   = stg_q + STG_W'(1);
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic issuing;
    assign issuing = (state_q == ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en       <= 1'b0;
            rd_addr_a   <= '0;
            rd_addr_b   <= '0;
            twiddle_num <= '0;
            stage       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_en       <= issuing;
            rd_addr_a   <= issuing ? bf_addr_a(k_q, stg_q) : '0;
            rd_addr_b   <= issuing ? bf_addr_a(k_q, stg_q) + bf_span(stg_q) : '0;
            twiddle_num <= issuing ? bf_twiddle(k_q, stg_q) : '0;
            stage       <= stg_q;
            busy        <= issuing || (state_q == DRAIN);
            done        <= (state_q == FINISH);
        end
    end

    fft_wb_delay #(
        .DEPTH (WB_DELAY),
        .AW    (ADDR_W)
    ) u_wb_delay (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (rd_en),
        .in_addr_a  (rd_addr_a),
        .in_addr_b  (rd_addr_b),
        .out_valid  (wr_en),
        .out_addr_a (wr_addr_a),
        .out_addr_b (wr_addr_b)
    );

endmodule

// File: tb/tb_fft_stage_controller.sv
// Directed self-checking bench for fft_stage_controller.
module tb_fft_stage_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       rd_en;
    logic [4:0] rd_addr_a;
    logic [4:0] rd_addr_b;
    logic [3:0] twiddle_num;
    logic       wr_en;
    logic [4:0] wr_addr_a;
    logic [4:0] wr_addr_b;
    logic [2:0] stage;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    fft_stage_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rd_en       (rd_en),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .twiddle_num (twiddle_num),
        .wr_en       (wr_en),
        .wr_addr_a   (wr_addr_a),
        .wr_addr_b   (wr_addr_b),
        .stage       (stage),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: upper leg is k with a zero bit inserted at position s.
    function automatic void ref_bf(input int s, input int k, output int a,
                                   output int b, output int tw);
        int span;
        int lo;
        span = 1 << s;
        lo   = k % span;
        a    = (k - lo) * 2 + lo;
        b    = a + span;
        tw   = lo * (16 / span);
    endfunction

    // Entered at the negedge right after the start-acceptance edge t;
    // checks cycles t+1..t+101 against the expected schedule.
    task automatic run_check(input string tag, input bit extra_starts,
                             output logic [31:0] seq[$]);
        int wr_cnt[5];
        int first_rd[5];
        int last_wr[5];
        int total_wr;
        int s, r, j, a, b, tw;
        bit exp_rd, exp_wr;
        seq = {};
        total_wr = 0;
        for (int q = 0; q < 5; q++) begin
            wr_cnt[q] = 0;
            first_rd[q] = -1;
            last_wr[q] = -1;
        end
        for (int i = 1; i <= 101; i++) begin
            @(negedge clk);
            s = (i - 1) / 20;
            r = (i - 1) % 20;
            exp_rd = (i <= 100) && (r < 16);
            check({tag, ".rd_en"}, rd_en, exp_rd);
            if (exp_rd) begin
                ref_bf(s, r, a, b, tw);
                check({tag, ".rd_a"}, rd_addr_a, a);
                check({tag, ".rd_b"}, rd_addr_b, b);
                check({tag, ".tw"}, twiddle_num, tw);
                check({tag, ".stage"}, stage, s);
            end
            if (rd_en) begin
                seq.push_back({5'd0, stage, 3'd0, rd_addr_a,
                               3'd0, rd_addr_b, 4'd0, twiddle_num});
                if (first_rd[s] < 0) first_rd[s] = i;
            end
            j = i - 4;
            exp_wr = (j >= 1) && (j <= 100) && (((j - 1) % 20) < 16);
            check({tag, ".wr_en"}, wr_en, exp_wr);
            if (exp_wr) begin
                ref_bf((j - 1) / 20, (j - 1) % 20, a, b, tw);
                check({tag, ".wr_a"}, wr_addr_a, a);
                check({tag, ".wr_b"}, wr_addr_b, b);
            end
            if (wr_en && j >= 1) begin
                wr_cnt[(j - 1) / 20]++;
                last_wr[(j - 1) / 20] = i;
                total_wr++;
            end
            check({tag, ".busy"}, busy, (i <= 100));
            check({tag, ".done"}, done, (i == 101));
            if (i == 1) begin
                check({tag, ".k0_a"}, rd_addr_a, 0);
                check({tag, ".k0_b"}, rd_addr_b, 1);
                check({tag, ".k0_tw"}, twiddle_num, 0);
            end
            if (i == 2) begin
                check({tag, ".k1_a"}, rd_addr_a, 2);
                check({tag, ".k1_b"}, rd_addr_b, 3);
                check({tag, ".k1_tw"}, twiddle_num, 0);
            end
            if (i == 5) begin
                check({tag, ".wr_first"}, wr_en, 1);
                check({tag, ".wr_first_a"}, wr_addr_a, 0);
                check({tag, ".wr_first_b"}, wr_addr_b, 1);
            end
            if (i == 46) begin
                check({tag, ".s2k5_a"}, rd_addr_a, 9);
                check({tag, ".s2k5_b"}, rd_addr_b, 13);
                check({tag, ".s2k5_tw"}, twiddle_num, 4);
            end
            if (i == 96) begin
                check({tag, ".s4k15_a"}, rd_addr_a, 15);
                check({tag, ".s4k15_b"}, rd_addr_b, 31);
                check({tag, ".s4k15_tw"}, twiddle_num, 15);
            end
            if (extra_starts) start = (i == 10) || (i == 50);
        end
        for (int q = 0; q < 5; q++) begin
            check({tag, ".wr_per_stage"}, wr_cnt[q], 16);
            if (q > 0)
                check({tag, ".barrier"},
                      (first_rd[q] > last_wr[q - 1] && last_wr[q - 1] > 0), 1);
        end
        check({tag, ".wr_total"}, total_wr, 80);
        check({tag, ".rd_total"}, seq.size(), 80);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] seq1[$];
    logic [31:0] seq2[$];
    int stray;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.rd_en", rd_en, 0);
        check("rst.wr_en", wr_en, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.stage", stage, 0);
        check("rst.rd_a", rd_addr_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single run with ignored mid-run start pulses.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_check("run1", 1'b1, seq1);
        repeat (6) begin
            @(negedge clk);
            check("post.rd_en", rd_en, 0);
            check("post.wr_en", wr_en, 0);
            check("post.done", done, 0);
        end

        // Reset in the middle of a run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        check("mid.busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid.rd_en", rd_en, 0);
        check("mid.wr_en", wr_en, 0);
        check("mid.busy", busy, 0);
        check("mid.stage", stage, 0);
        check("mid.done", done, 0);
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (wr_en || rd_en || busy || done) stray++;
        end
        check("mid.no_activity", stray, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_check("after_rst", 1'b0, seq2);

        // Start held high: back-to-back runs.
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        run_check("b2b1", 1'b0, seq1);
        @(negedge clk);
        check("b2b.idle_gap_rd", rd_en, 0);
        run_check("b2b2", 1'b0, seq2);
        start = 1'b0;
        check("b2b.seq_len", seq2.size(), seq1.size());
        for (int i = 0; i < seq1.size() && i < seq2.size(); i++)
            check("b2b.seq", seq2[i], seq1[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
